seg7_frame_decoder: RTL and testbench



---
 rtl/seg7_frame_decoder.sv | 140 ++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_decoder.sv
// Observes a multiplexed active-high 7-segment scan and rebuilds the displayed
// hex value, issuing a valid pulse once every digit position has been captured.
module seg7_frame_decoder #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DIGITS-1:0]                dig_sel,
    input  logic [6:0]                       segment,
    output logic [4*DIGITS-1:0]              value,
    output logic                             valid,
    output logic                             err,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] err_digit
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(STABLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE - 2);

    // Returns {legal, nibble}; anything outside the sixteen glyphs is illegal.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   glyph_decode = {1'b1, 4'h0};
            7'h06:   glyph_decode = {1'b1, 4'h1};
            7'h5B:   glyph_decode = {1'b1, 4'h2};
            7'h4F:   glyph_decode = {1'b1, 4'h3};
            7'h66:   glyph_decode = {1'b1, 4'h4};
            7'h6D:   glyph_decode = {1'b1, 4'h5};
            7'h7D:   glyph_decode = {1'b1, 4'h6};
            7'h07:   glyph_decode = {1'b1, 4'h7};
            7'h7F:   glyph_decode = {1'b1, 4'h8};
            7'h6F:   glyph_decode = {1'b1, 4'h9};
            7'h77:   glyph_decode = {1'b1, 4'hA};
            7'h7C:   glyph_decode = {1'b1, 4'hB};
            7'h39:   glyph_decode = {1'b1, 4'hC};
            7'h5E:   glyph_decode = {1'b1, 4'hD};
            7'h79:   glyph_decode = {1'b1, 4'hE};
            7'h71:   glyph_decode = {1'b1, 4'hF};
            default: glyph_decode = {1'b0, 4'h0};
        endcase
    endfunction

    logic [DIGITS-1:0]   prev_sel;
    logic [6:0]          prev_seg;
    logic [CW-1:0]       cnt;
    logic                done;
    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   cap_mask;

    logic                sel_onehot;
    logic                same;
    logic [IW-1:0]       sel_idx;
    logic [4:0]          glyph;
    logic                capture;
    logic                cap_legal;
    logic                cap_illegal;
    logic [DIGITS-1:0]   mask_set;
    logic                frame_done;
    logic [4*DIGITS-1:0] shadow_upd;
    logic [CW-1:0]       cnt_next;
    logic                done_next;

    // Dwell tracking: a capture fires on the STABLE-th identical one-hot sample,
    // and done suppresses further captures until the sample changes.
    always_comb begin
        sel_onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
        same        = sel_onehot && (dig_sel == prev_sel) && (segment == prev_seg);
        glyph       = glyph_decode(segment);
        sel_idx     = '0;
        shadow_upd  = shadow;
        cnt_next    = cnt;
        done_next   = done;

        for (int i = 0; i < DIGITS; i++) begin
            if (dig_sel[i]) begin
                sel_idx               = IW'(i);
                shadow_upd[i*4 +: 4]  = glyph[3:0];
            end
        end

        if (same) begin
            if (cnt != CNT_MAX) begin
                cnt_next = cnt + CW'(1);
            end
        end else begin
            cnt_next  = '0;
            done_next = 1'b0;
        end

        capture = same && !done && (cnt >= CNT_ARM);
        if (capture) begin
            done_next = 1'b1;
        end

        cap_legal   = capture && glyph[4];
        cap_illegal = capture && !glyph[4];
        mask_set    = cap_mask | dig_sel;
        frame_done  = cap_legal && (&mask_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sel  <= '0;
            prev_seg  <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            shadow    <= '0;
            cap_mask  <= '0;
            value     <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            err_digit <= '0;
        end else begin
            prev_sel <= dig_sel;
            prev_seg <= segment;
            cnt      <= cnt_next;
            done     <= done_next;
            valid    <= 1'b0;
            err      <= 1'b0;
            if (cap_legal) begin
                shadow <= shadow_upd;
                // The completing nibble is folded straight into the published frame.
                if (frame_done) begin
                    value    <= shadow_upd;
                    valid    <= 1'b1;
                    cap_mask <= '0;
                end else begin
                    cap_mask <= mask_set;
                end
            end else if (cap_illegal) begin
                err       <= 1'b1;
                err_digit <= sel_idx;
                cap_mask  <= cap_mask & ~dig_sel;
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed self-checking bench for seg7_frame_decoder (DIGITS=4, STABLE=3)
// with hand-computed expected frames.
module tb_seg7_frame_decoder;

    logic        clk;
    logic        rst;
    logic [3:0]  dig_sel;
    logic [6:0]  segment;
    logic [15:0] value;
    logic        valid;
    logic        err;
    logic [1:0]  err_digit;

    int checks   = 0;
    int failures = 0;
    int valid_seen = 0;
    int err_seen   = 0;
    int v_base;
    int e_base;

    seg7_frame_decoder #(.DIGITS(4), .STABLE(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .dig_sel   (dig_sel),
        .segment   (segment),
        .value     (value),
        .valid     (valid),
        .err       (err),
        .err_digit (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (valid) valid_seen++;
        if (err)   err_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg, input int n);
        @(negedge clk);
        dig_sel = sel;
        segment = seg;
        repeat (n) @(posedge clk);
    endtask

    task automatic scanDigit(input int pos, input logic [6:0] seg, input int n);
        applyStimulus(4'(1 << pos), seg, n);
        applyStimulus(4'b0000, 7'h00, 1);
    endtask

    task automatic markCounts();
        v_base = valid_seen;
        e_base = err_seen;
    endtask

    initial begin
        rst     = 1'b1;
        dig_sel = '0;
        segment = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_value", 32'(value), 32'h0);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        checkOutput("reset_err_digit", 32'(err_digit), 32'h0);

        $display("[TB] basic frame");
        markCounts();
        scanDigit(0, 7'h06, 4);
        scanDigit(1, 7'h5B, 4);
        scanDigit(2, 7'h4F, 4);
        applyStimulus(4'b1000, 7'h66, 2);
        #1 checkOutput("basic_no_early_valid", 32'(valid), 32'h0);
        applyStimulus(4'b1000, 7'h66, 1);
        #1 checkOutput("basic_valid_3rd_edge", 32'(valid), 32'h1);
        checkOutput("basic_value", 32'(value), 32'h4321);
        applyStimulus(4'b1000, 7'h66, 1);
        applyStimulus(4'b0000, 7'h00, 1);
        checkOutput("basic_valid_count", 32'(valid_seen - v_base), 32'd1);
        checkOutput("basic_err_count", 32'(err_seen - e_base), 32'd0);

        $display("[TB] glitch rejection");
        markCounts();
        scanDigit(1, 7'h7D, 4);
        scanDigit(2, 7'h07, 4);
        scanDigit(3, 7'h7F, 4);
        applyStimulus(4'b0001, 7'h3F, 2);
        #1 checkOutput("glitch_no_capture", 32'(valid), 32'h0);
        applyStimulus(4'b0001, 7'h06, 3);
        #1 checkOutput("glitch_valid", 32'(valid), 32'h1);
        checkOutput("glitch_value", 32'(value), 32'h8761);
        applyStimulus(4'b0000, 7'h00, 1);
        checkOutput("glitch_valid_count", 32'(valid_seen - v_base), 32'd1);
        checkOutput("glitch_err_count", 32'(err_seen - e_base), 32'd0);

        $display("[TB] illegal glyph");
        markCounts();
        scanDigit(0, 7'h6F, 4);
        scanDigit(1, 7'h77, 4);
        applyStimulus(4'b0100, 7'h7E, 3);
        #1 checkOutput("illegal_err", 32'(err), 32'h1);
        checkOutput("illegal_err_digit", 32'(err_digit), 32'h2);
        applyStimulus(4'b0000, 7'h00, 1);
        #1 checkOutput("illegal_err_pulse_end", 32'(err), 32'h0);
        scanDigit(3, 7'h39, 4);
        checkOutput("illegal_no_valid", 32'(valid_seen - v_base), 32'd0);
        checkOutput("illegal_err_digit_held", 32'(err_digit), 32'h2);
        scanDigit(2, 7'h79, 4);
        checkOutput("illegal_valid_count", 32'(valid_seen - v_base), 32'd1);
        checkOutput("illegal_value", 32'(value), 32'hCEA9);
        checkOutput("illegal_err_count", 32'(err_seen - e_base), 32'd1);

        $display("[TB] long dwell and overwrite");
        markCounts();
        scanDigit(0, 7'h71, 4);
        scanDigit(1, 7'h5E, 20);
        checkOutput("dwell_no_valid", 32'(valid_seen - v_base), 32'd0);
        scanDigit(1, 7'h7C, 4);
        scanDigit(2, 7'h6D, 4);
        scanDigit(3, 7'h3F, 4);
        checkOutput("dwell_valid_count", 32'(valid_seen - v_base), 32'd1);
        checkOutput("dwell_value", 32'(value), 32'h05BF);
        checkOutput("dwell_err_count", 32'(err_seen - e_base), 32'd0);

        $display("[TB] reset mid-frame");
        markCounts();
        scanDigit(0, 7'h06, 4);
        scanDigit(1, 7'h06, 4);
        scanDigit(2, 7'h06, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_value_cleared", 32'(value), 32'h0);
        scanDigit(3, 7'h5B, 4);
        checkOutput("rst_no_valid", 32'(valid_seen - v_base), 32'd0);
        checkOutput("rst_value_held", 32'(value), 32'h0);
        scanDigit(0, 7'h6D, 4);
        scanDigit(1, 7'h66, 4);
        scanDigit(2, 7'h4F, 4);
        scanDigit(3, 7'h5B, 4);
        checkOutput("rst_rescan_valid", 32'(valid_seen - v_base), 32'd1);
        checkOutput("rst_rescan_value", 32'(value), 32'h2345);

        $display("[TB] multi-hot and blank");
        markCounts();
        applyStimulus(4'b0011, 7'h06, 10);
        applyStimulus(4'b0000, 7'h06, 10);
        checkOutput("multi_no_valid", 32'(valid_seen - v_base), 32'd0);
        checkOutput("multi_no_err", 32'(err_seen - e_base), 32'd0);
        scanDigit(2, 7'h66, 4);
        scanDigit(3, 7'h07, 4);
        checkOutput("multi_no_stray_capture", 32'(valid_seen - v_base), 32'd0);
        checkOutput("multi_value_held", 32'(value), 32'h2345);
        scanDigit(0, 7'h3F, 4);
        scanDigit(1, 7'h7F, 4);
        checkOutput("multi_valid_count", 32'(valid_seen - v_base), 32'd1);
        checkOutput("multi_value", 32'(value), 32'h7480);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
